// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: widths, starvation limit default, owner encoding
// and the command bundle presented to the memory port.
package mem_bus_pkg;

  localparam int BUS_ADDR_W           = 32;
  localparam int BUS_DATA_W           = 32;
  localparam int STARVE_CNT_W         = 8;
  localparam int STARVE_LIMIT_DEFAULT = 8;

  typedef logic [BUS_ADDR_W-1:0]   busAddr_t;
  typedef logic [BUS_DATA_W-1:0]   busData_t;
  typedef logic [STARVE_CNT_W-1:0] starveCnt_t;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_CPU,
    OWNER_DMA
  } busOwner_e;

  typedef struct packed {
    busAddr_t addr;
    busData_t wdata;
    logic     read;
    logic     write;
  } memCmd_t;

  // CPU wins by default; the DMA takes the bus when the CPU is idle or it has starved.
  function automatic busOwner_e selectOwner(input logic cpuAccess,
                                            input logic dmaReq,
                                            input logic starved);
    busOwner_e owner;
    if (dmaReq && (!cpuAccess || starved)) owner = OWNER_DMA;
    else if (cpuAccess)                     owner = OWNER_CPU;
    else                                    owner = OWNER_NONE;
    return owner;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single-ported data memory: CPU MEM stage has priority,
// a DMA requester is forced through after STARVE_LIMIT consecutive losses.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [BUS_ADDR_W-1:0] cpu_addr,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [BUS_DATA_W-1:0] cpu_wdata,
  output logic [BUS_DATA_W-1:0] cpu_rdata,
  output logic                  cpu_stall,

  input  logic                  dma_req,
  input  logic                  dma_write,
  input  logic [BUS_ADDR_W-1:0] dma_addr,
  input  logic [BUS_DATA_W-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic [BUS_DATA_W-1:0] dma_rdata,
  output logic                  dma_rvalid,

  output logic [BUS_ADDR_W-1:0] mem_addr,
  output logic [BUS_DATA_W-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [BUS_DATA_W-1:0] mem_rdata
);

  localparam starveCnt_t LIMIT = starveCnt_t'(STARVE_LIMIT);

  starveCnt_t starveCnt;
  busOwner_e  owner;
  memCmd_t    cpuCmd;
  memCmd_t    dmaCmd;
  memCmd_t    memCmd;
  logic       cpuAccess;
  logic       starved;
  logic       dmaGnt;
  logic       dmaRdGnt;

  assign cpuAccess = cpu_read | cpu_write;
  assign starved   = (starveCnt == LIMIT);
  assign owner     = selectOwner(cpuAccess, dma_req, starved);
  assign dmaGnt    = (owner == OWNER_DMA);
  assign dmaRdGnt  = dmaGnt & ~dma_write;

  // A simultaneous read+write strobe from the CPU is a store only.
  assign cpuCmd = '{addr: cpu_addr, wdata: cpu_wdata,
                    read: cpu_read & ~cpu_write, write: cpu_write};
  assign dmaCmd = '{addr: dma_addr, wdata: dma_wdata,
                    read: ~dma_write, write: dma_write};

  // NOTE: every always_comb output gets a default before the case so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    memCmd       = cpuCmd;
    memCmd.read  = 1'b0;
    memCmd.write = 1'b0;
    unique case (owner)
      OWNER_CPU:  memCmd = cpuCmd;
      OWNER_DMA:  memCmd = dmaCmd;
      default:    ;
    endcase
  end

  assign mem_addr  = memCmd.addr;
  assign mem_wdata = memCmd.wdata;
  assign mem_read  = memCmd.read;
  assign mem_write = memCmd.write;

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = dmaGnt & cpuAccess;
  assign dma_gnt   = dmaGnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starveCnt <= '0;
    end else if (!dma_req || dmaGnt) begin
      starveCnt <= '0;
    end else if (starveCnt != LIMIT) begin
      starveCnt <= starveCnt + starveCnt_t'(1);
    end
  end

  // Read return: one-cycle latency, data held until the next DMA read grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dmaRdGnt;
      if (dmaRdGnt) dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: behavioural memory, inline checks of
// the combinational arbitration and a scoreboard queue for DMA read returns.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int LIMIT = 8;

  logic     clk;
  logic     reset;
  busAddr_t cpu_addr;
  logic     cpu_read;
  logic     cpu_write;
  busData_t cpu_wdata;
  busData_t cpu_rdata;
  logic     cpu_stall;
  logic     dma_req;
  logic     dma_write;
  busAddr_t dma_addr;
  busData_t dma_wdata;
  logic     dma_gnt;
  busData_t dma_rdata;
  logic     dma_rvalid;
  busAddr_t mem_addr;
  busData_t mem_wdata;
  logic     mem_read;
  logic     mem_write;
  busData_t mem_rdata;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_write  (dma_write),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory, 256 words addressed by the low address byte, plus a preload port.
  busData_t memArr [0:255];
  logic     loadEn;
  logic [7:0] loadAddr;
  busData_t loadData;

  assign mem_rdata = memArr[mem_addr[7:0]];

  always @(posedge clk) begin
    if (loadEn)         memArr[loadAddr]      <= loadData;
    else if (mem_write) memArr[mem_addr[7:0]] <= mem_wdata;
  end

  int       checkCnt = 0;
  int       passCnt  = 0;
  busData_t expQ [$];
  busData_t expData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    cpu_addr  = '0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_wdata = '0;
    dma_req   = 1'b0;
    dma_write = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
  endtask

  task automatic preload(input logic [7:0] a, input busData_t d);
    loadEn   = 1'b1;
    loadAddr = a;
    loadData = d;
    tick();
    loadEn   = 1'b0;
  endtask

  // Scoreboard: every DMA read return must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && dma_rvalid) begin
      if (expQ.size() == 0) begin
        check("rvalid_unexpected", 32'(dma_rvalid), 32'd0);
      end else begin
        expData = expQ.pop_front();
        check("sb_dma_rdata", dma_rdata, expData);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    loadEn   = 1'b0;
    loadAddr = '0;
    loadData = '0;
    idleInputs();
    #2;
    check("rst_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_rdata",  dma_rdata,       32'd0);
    check("rst_gnt",    32'(dma_gnt),    32'd0);
    check("rst_strobe", {30'd0, mem_read, mem_write}, 32'd0);

    preload(8'h10, 32'hDEAD_BEEF);
    preload(8'h84, 32'h1234_5678);
    preload(8'h40, 32'h0000_0000);
    reset = 1'b0;
    tick();

    // Idle CPU: DMA read granted same cycle, data one cycle later.
    dma_req = 1'b1; dma_write = 1'b0; dma_addr = 32'h10;
    #1;
    check("t1_gnt",      32'(dma_gnt),   32'd1);
    check("t1_stall",    32'(cpu_stall), 32'd0);
    check("t1_mem_read", 32'(mem_read),  32'd1);
    check("t1_mem_addr", mem_addr,       32'h10);
    expQ.push_back(32'hDEAD_BEEF);
    tick();
    dma_req = 1'b0;
    #1;
    check("t1_rvalid", 32'(dma_rvalid), 32'd1);
    check("t1_rdata",  dma_rdata,       32'hDEAD_BEEF);
    tick();

    // Back-to-back reads: two pulses, in order, data held afterwards.
    dma_req = 1'b1; dma_addr = 32'h10;
    expQ.push_back(32'hDEAD_BEEF);
    tick();
    dma_addr = 32'h84;
    expQ.push_back(32'h1234_5678);
    #1;
    check("b2b_rvalid1", 32'(dma_rvalid), 32'd1);
    tick();
    dma_req = 1'b0;
    #1;
    check("b2b_rvalid2", 32'(dma_rvalid), 32'd1);
    check("b2b_rdata2",  dma_rdata,       32'h1234_5678);
    tick();
    #1;
    check("b2b_rvalid_end", 32'(dma_rvalid), 32'd0);
    check("b2b_rdata_hold", dma_rdata,       32'h1234_5678);

    // Starvation: 8 losses, forced grant on the 9th cycle, CPU back on the 10th.
    cpu_read = 1'b1; cpu_addr = 32'h80;
    dma_req  = 1'b1; dma_write = 1'b0; dma_addr = 32'h84;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      check($sformatf("st_gnt%0d", i),   32'(dma_gnt),       32'd0);
      check($sformatf("st_stall%0d", i), 32'(cpu_stall),     32'd0);
      check($sformatf("st_cnt%0d", i),   32'(dut.starveCnt), 32'(i));
      tick();
    end
    #1;
    check("st_forced_gnt",   32'(dma_gnt),   32'd1);
    check("st_forced_stall", 32'(cpu_stall), 32'd1);
    check("st_forced_addr",  mem_addr,       32'h84);
    expQ.push_back(32'h1234_5678);
    tick();
    #1;
    check("st_cpu_gnt",   32'(dma_gnt),       32'd0);
    check("st_cpu_stall", 32'(cpu_stall),     32'd0);
    check("st_cpu_addr",  mem_addr,          32'h80);
    check("st_cnt_clr",   32'(dut.starveCnt), 32'd0);
    idleInputs();
    tick();

    // Read+write together is a store only.
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h5;
    #1;
    check("rw_mem_write", 32'(mem_write), 32'd1);
    check("rw_mem_read",  32'(mem_read),  32'd0);
    tick();
    idleInputs();
    #1;
    check("rw_mem_data", memArr[8'h20], 32'h5);

    // DMA write then CPU load of the same word; no rvalid from the write.
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hA5A5;
    #1;
    check("dw_gnt",       32'(dma_gnt),   32'd1);
    check("dw_mem_write", 32'(mem_write), 32'd1);
    tick();
    idleInputs();
    cpu_read = 1'b1; cpu_addr = 32'h40;
    #1;
    check("dw_cpu_rdata", cpu_rdata,       32'h0000_A5A5);
    check("dw_no_rvalid", 32'(dma_rvalid), 32'd0);
    tick();
    idleInputs();

    // Reset pulsed between a DMA read grant and the next edge drops the return.
    dma_req = 1'b1; dma_write = 1'b0; dma_addr = 32'h10;
    #1;
    check("rr_gnt", 32'(dma_gnt), 32'd1);
    #1;
    reset   = 1'b1;
    dma_req = 1'b0;
    #1;
    check("rr_async_rdata", dma_rdata, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check("rr_rvalid", 32'(dma_rvalid), 32'd0);
    check("rr_rdata",  dma_rdata,       32'd0);

    // Dropped request restarts the count; forced grant after 8 fresh losses.
    cpu_read = 1'b1; cpu_addr = 32'h80;
    dma_req  = 1'b1; dma_write = 1'b1; dma_addr = 32'h60; dma_wdata = 32'h77;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("dr_gnt%0d", i), 32'(dma_gnt), 32'd0);
      tick();
    end
    dma_req = 1'b0;
    #1;
    check("dr_drop_gnt", 32'(dma_gnt), 32'd0);
    tick();
    dma_req = 1'b1;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      check($sformatf("dr2_gnt%0d", i), 32'(dma_gnt),       32'd0);
      check($sformatf("dr2_cnt%0d", i), 32'(dut.starveCnt), 32'(i));
      tick();
    end
    #1;
    check("dr2_forced_gnt",   32'(dma_gnt),   32'd1);
    check("dr2_forced_stall", 32'(cpu_stall), 32'd1);
    check("dr2_forced_write", 32'(mem_write), 32'd1);
    tick();
    idleInputs();
    #1;
    check("dr2_mem_data", memArr[8'h60], 32'h77);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) tick();
    check("sb_drain", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
